// File: rtl/axi_host_arbiter.sv
// Arbitrates NUM_REQ single-request requesters onto one simple_axi_master host port.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module axi_host_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [2*NUM_REQ-1:0]    i_req_rw,
    input  logic [3*NUM_REQ-1:0]    i_req_size,
    input  logic [32*NUM_REQ-1:0]   i_req_addr,
    input  logic [64*NUM_REQ-1:0]   i_req_wdata,
    output logic [NUM_REQ-1:0]      o_req_ack,
    output logic                    o_req_error,
    output logic                    o_req_invalid,
    output logic [63:0]             o_req_rdata,
    output logic [IDX_W-1:0]        o_grant,
    output logic                    o_busy,
    output logic [2:0]              o_m_size,
    output logic [31:0]             o_m_addr,
    output logic [63:0]             o_m_wdata,
    output logic [1:0]              o_m_rw,
    output logic                    o_m_clear,
    input  logic [63:0]             i_m_rdata,
    input  logic                    i_m_wait,
    input  logic                    i_m_done,
    input  logic                    i_m_error,
    input  logic                    i_m_invalid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t state, state_n;

    logic [1:0]           rw_a    [NUM_REQ];
    logic [2:0]           size_a  [NUM_REQ];
    logic [31:0]          addr_a  [NUM_REQ];
    logic [63:0]          wdata_a [NUM_REQ];
    logic [NUM_REQ-1:0]   active;

    logic                 found;
    logic [IDX_W-1:0]     winner;

    logic                 load;
    logic                 capture;
    logic                 capture_rdata;

    logic [IDX_W-1:0]     grant;
    logic [1:0]           lat_rw;
    logic [2:0]           lat_size;
    logic [31:0]          lat_addr;
    logic [63:0]          lat_wdata;
    logic                 req_error;
    logic                 req_invalid;
    logic [63:0]          req_rdata;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rw_a[i]    = i_req_rw[2*i +: 2];
            size_a[i]  = i_req_size[3*i +: 3];
            addr_a[i]  = i_req_addr[32*i +: 32];
            wdata_a[i] = i_req_wdata[64*i +: 64];
            // Code 11 is deliberately not an active request.
            active[i]  = (rw_a[i] == 2'b01) || (rw_a[i] == 2'b10);
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && active[IDX_W'(i)]) begin
                found  = 1'b1;
                winner = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;

    // Search starts one past the last winner so the last winner is considered last.
    always_comb begin
        int cand;
        found  = 1'b0;
        winner = '0;
        cand   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && active[IDX_W'(cand)]) begin
                found  = 1'b1;
                winner = IDX_W'(cand);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr <= IDX_W'(NUM_REQ - 1);
        end else if (state == ST_IDLE && found) begin
            rr_ptr <= winner;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        load          = 1'b0;
        capture       = 1'b0;
        capture_rdata = 1'b0;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    load    = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Completion while not waiting here means the master rejected the access outright.
                if (i_m_done && !i_m_wait) begin
                    capture = 1'b1;
                    state_n = ST_ACK;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_m_done && !i_m_wait) begin
                    capture       = 1'b1;
                    capture_rdata = (lat_rw == 2'b10);
                    state_n       = ST_ACK;
                end
            end
            ST_ACK: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            grant       <= '0;
            lat_rw      <= 2'b00;
            lat_size    <= 3'd0;
            lat_addr    <= 32'd0;
            lat_wdata   <= 64'd0;
            req_error   <= 1'b0;
            req_invalid <= 1'b0;
            req_rdata   <= 64'd0;
        end else begin
            if (load) begin
                grant     <= winner;
                lat_rw    <= rw_a[winner];
                lat_size  <= size_a[winner];
                lat_addr  <= addr_a[winner];
                lat_wdata <= wdata_a[winner];
            end
            if (capture) begin
                req_error   <= i_m_error;
                req_invalid <= i_m_invalid;
            end
            if (capture_rdata) begin
                req_rdata <= i_m_rdata;
            end
        end
    end

    assign o_req_ack     = (state == ST_ACK) ? (NUM_REQ'(1) << grant) : '0;
    assign o_req_error   = req_error;
    assign o_req_invalid = req_invalid;
    assign o_req_rdata   = req_rdata;
    assign o_grant       = grant;
    assign o_busy        = (state != ST_IDLE);
    assign o_m_rw        = (state == ST_ISSUE) ? lat_rw : 2'b00;
    assign o_m_size      = lat_size;
    assign o_m_addr      = lat_addr;
    assign o_m_wdata     = lat_wdata;
    assign o_m_clear     = 1'b1;

endmodule

// File: tb/tb_axi_host_arbiter.sv
// Scoreboard bench for axi_host_arbiter with a behavioural master model.
// Honours ARB_FIXED_PRIO_EN when choosing expected grant order.
module tb_axi_host_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef struct {
        int          idx;
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic        err;
        logic        inv;
        logic        chk_rd;
        logic [63:0] rdata;
        int          lat;
        int          req_cyc;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [2*NUM_REQ-1:0]   req_rw;
    logic [3*NUM_REQ-1:0]   req_size;
    logic [32*NUM_REQ-1:0]  req_addr;
    logic [64*NUM_REQ-1:0]  req_wdata;
    logic [NUM_REQ-1:0]     ack;
    logic                   req_error, req_invalid, busy, m_clear;
    logic [63:0]            req_rdata, m_wdata, m_rdata;
    logic [IDX_W-1:0]       grant;
    logic [2:0]             m_size;
    logic [31:0]            m_addr;
    logic [1:0]             m_rw;
    logic                   m_wait, m_done, m_err, m_inv;

    logic [1:0]  rq_rw    [NUM_REQ];
    logic [2:0]  rq_size  [NUM_REQ];
    logic [31:0] rq_addr  [NUM_REQ];
    logic [63:0] rq_wdata [NUM_REQ];
    logic        hold_req [NUM_REQ];

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          resp_lat = 0;
    logic        resp_err = 1'b0;
    logic        resp_inv = 1'b0;
    logic [63:0] resp_rdata = 64'd0;
    logic [63:0] last_rdata = 64'd0;

    axi_host_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_rw(req_rw), .i_req_size(req_size), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_req_ack(ack), .o_req_error(req_error), .o_req_invalid(req_invalid),
        .o_req_rdata(req_rdata), .o_grant(grant), .o_busy(busy),
        .o_m_size(m_size), .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_rw(m_rw),
        .o_m_clear(m_clear), .i_m_rdata(m_rdata), .i_m_wait(m_wait), .i_m_done(m_done),
        .i_m_error(m_err), .i_m_invalid(m_inv)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_rw    = '0;
        req_size  = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rw[2*i +: 2]     = rq_rw[i];
            req_size[3*i +: 3]   = rq_size[i];
            req_addr[32*i +: 32] = rq_addr[i];
            req_wdata[64*i +: 64] = rq_wdata[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic pushExpect(input int idx, input logic [1:0] rw, input logic [2:0] size,
                              input logic [31:0] addr, input logic [63:0] wdata, input int lat);
        exp_t e;
        logic misal;
        misal     = (addr & ((32'd1 << size) - 32'd1)) != 32'd0;
        e.idx     = idx;
        e.rw      = rw;
        e.addr    = addr;
        e.wdata   = wdata;
        e.err     = misal ? 1'b1 : resp_err;
        e.inv     = misal ? 1'b1 : resp_inv;
        e.chk_rd  = !misal;
        if (rw == 2'b10 && !misal) last_rdata = resp_rdata;
        e.rdata   = last_rdata;
        e.lat     = lat;
        e.req_cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic driveReq(input int idx, input logic [1:0] rw, input logic [2:0] size,
                            input logic [31:0] addr, input logic [63:0] wdata);
        rq_rw[idx]    = rw;
        rq_size[idx]  = size;
        rq_addr[idx]  = addr;
        rq_wdata[idx] = wdata;
    endtask

    task automatic applyStimulus(input int idx, input logic [1:0] rw, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [63:0] wdata, input int lat);
        pushExpect(idx, rw, size, addr, wdata, lat);
        driveReq(idx, rw, size, addr, wdata);
    endtask

    task automatic waitDone();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checkOutput("ack_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            driveReq(i, 2'b00, 3'd0, 32'd0, 64'd0);
            hold_req[i] = 1'b0;
        end
        exp_q.delete();
        last_rdata = 64'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Behavioural master: rejects misaligned accesses at once, otherwise waits resp_lat cycles.
    initial begin
        logic [1:0] cur_rw;
        int cnt;
        cur_rw = 2'b00;
        cnt    = 0;
        m_wait = 1'b0; m_done = 1'b0; m_err = 1'b0; m_inv = 1'b0; m_rdata = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !busy || (ack != '0)) begin
                m_done = 1'b0;
                m_wait = 1'b0;
            end else if (m_rw != 2'b00) begin
                cur_rw = m_rw;
                if (exp_q.size() > 0) begin
                    checkOutput("m_rw", 64'(m_rw), 64'(exp_q[0].rw));
                    checkOutput("m_addr", 64'(m_addr), 64'(exp_q[0].addr));
                    if (exp_q[0].rw == 2'b01) checkOutput("m_wdata", m_wdata, exp_q[0].wdata);
                end
                if ((m_addr & ((32'd1 << m_size) - 32'd1)) != 32'd0) begin
                    m_done = 1'b1; m_wait = 1'b0; m_err = 1'b1; m_inv = 1'b1;
                end else begin
                    m_done = 1'b0; m_wait = 1'b1; cnt = resp_lat;
                end
            end else if (cnt == 0) begin
                m_done  = 1'b1;
                m_wait  = 1'b0;
                m_err   = resp_err;
                m_inv   = resp_inv;
                m_rdata = (cur_rw == 2'b10) ? resp_rdata : 64'hBAD0_BAD0_BAD0_BAD0;
            end else begin
                cnt--;
            end
        end
    end

    // Ack monitor: pops the scoreboard, checks status, and releases non-held requesters.
    initial begin
        logic [NUM_REQ-1:0] prev_ack;
        exp_t e;
        prev_ack = '0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_ack != '0) checkOutput("ack_pulse", 64'(ack), 64'd0);
            prev_ack = rst ? '0 : ack;
            if (!rst && ack != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_ack", 64'(ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("ack_vec", 64'(ack), 64'd1 << e.idx);
                    checkOutput("grant", 64'(grant), 64'(e.idx));
                    checkOutput("error", 64'(req_error), 64'(e.err));
                    checkOutput("invalid", 64'(req_invalid), 64'(e.inv));
                    if (e.chk_rd) checkOutput("rdata", req_rdata, e.rdata);
                    if (e.lat >= 0) checkOutput("latency", 64'(cyc - e.req_cyc), 64'(e.lat));
                    if (!hold_req[e.idx]) rq_rw[e.idx] = 2'b00;
                end
            end
        end
    end

    initial begin
        int seq [4];
        rst = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            driveReq(i, 2'b00, 3'd0, 32'd0, 64'd0);
            hold_req[i] = 1'b0;
        end
        doReset();

        @(negedge clk);
        checkOutput("rst_ack", 64'(ack), 64'd0);
        checkOutput("rst_error", 64'(req_error), 64'd0);
        checkOutput("rst_invalid", 64'(req_invalid), 64'd0);
        checkOutput("rst_rdata", req_rdata, 64'd0);
        checkOutput("rst_grant", 64'(grant), 64'd0);
        checkOutput("rst_m_rw", 64'(m_rw), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("m_clear", 64'(m_clear), 64'd1);

        $display("[TB] single aligned read");
        resp_lat = 2; resp_err = 1'b0; resp_inv = 1'b0; resp_rdata = 64'hDEAD_BEEF;
        applyStimulus(0, 2'b10, 3'd2, 32'h100, 64'd0, 5);
        waitDone();
        checkOutput("rdata_held", req_rdata, 64'hDEAD_BEEF);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        $display("[TB] four simultaneous writes");
        doReset();
        @(negedge clk);
        resp_lat = 1;
        for (int i = 0; i < NUM_REQ; i++)
            applyStimulus(i, 2'b01, 3'd3, 32'h1000 + 32'(8*i), 64'h1111 * 64'(i + 1), (i == 0) ? 4 : -1);
        waitDone();

        $display("[TB] misaligned read");
        applyStimulus(1, 2'b10, 3'd2, 32'h3, 64'd0, 2);
        waitDone();

        $display("[TB] read then failing write");
        resp_lat = 0; resp_rdata = 64'h0000_0000_CAFE_F00D;
        applyStimulus(3, 2'b10, 3'd3, 32'h200, 64'd0, 3);
        waitDone();
        resp_err = 1'b1; resp_inv = 1'b0;
        applyStimulus(2, 2'b01, 3'd1, 32'h302, 64'h55AA, 3);
        waitDone();
        checkOutput("rdata_after_write", req_rdata, 64'h0000_0000_CAFE_F00D);
        resp_err = 1'b0;

        $display("[TB] continuous requesters 0 and 3");
        doReset();
        @(negedge clk);
`ifdef ARB_FIXED_PRIO_EN
        seq = '{0, 0, 0, 0};
`else
        seq = '{0, 3, 0, 3};
`endif
        hold_req[0] = 1'b1;
        hold_req[3] = 1'b1;
        for (int k = 0; k < 4; k++)
            pushExpect(seq[k], 2'b01, 3'd2, 32'h2000 + 32'(16*seq[k]), 64'(seq[k]), -1);
        driveReq(0, 2'b01, 3'd2, 32'h2000, 64'd0);
        driveReq(3, 2'b01, 3'd2, 32'h2030, 64'd3);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("cont_remaining", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        driveReq(0, 2'b00, 3'd0, 32'd0, 64'd0);
        driveReq(3, 2'b00, 3'd0, 32'd0, 64'd0);
        hold_req[0] = 1'b0;
        hold_req[3] = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] reset during wait");
        resp_lat = 10; resp_rdata = 64'h1;
        applyStimulus(2, 2'b10, 3'd3, 32'h40, 64'd0, -1);
        repeat (4) @(negedge clk);
        checkOutput("busy_in_wait", 64'(busy), 64'd1);
        rst = 1'b1;
        driveReq(2, 2'b00, 3'd0, 32'd0, 64'd0);
        exp_q.delete();
        last_rdata = 64'd0;
        @(negedge clk);
        checkOutput("rst_mid_busy", 64'(busy), 64'd0);
        checkOutput("rst_mid_ack", 64'(ack), 64'd0);
        checkOutput("rst_mid_rdata", req_rdata, 64'd0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        resp_lat = 2; resp_rdata = 64'h1234_5678;
        applyStimulus(1, 2'b10, 3'd2, 32'h80, 64'd0, 5);
        waitDone();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
